operand_seq_ctrl: RTL and testbench

OPERAND_SEQ_CTRL -- requirements
Module: operand_seq_ctrl

---
 rtl/operand_seq_ctrl_pkg.sv | 36 +++
 rtl/operand_seq_ctrl_if.sv | 24 ++
 rtl/operand_seq_ctrl_instr_decode.sv | 28 ++
 rtl/operand_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_operand_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_seq_ctrl_pkg.sv
// Shared encodings for the operand sequencing controller: opcodes, FSM
// states and operand-source select codes (also used by mux_mem_rf_imm).
package operand_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOV  = 4'h1,
    OP_LDI  = 4'h2,
    OP_LD   = 4'h3,
    OP_ST   = 4'h4,
    OP_JMP  = 4'h5,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_IMM = 2'b10;

  function automatic logic opcode_is_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_MOV, OP_LDI, OP_LD, OP_ST, OP_JMP, OP_HALT: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_seq_ctrl_if.sv
// Instruction-fetch and data-memory handshake bundle.
interface operand_seq_ctrl_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   instr_req;
  logic [DATA_WIDTH-1:0]  instr_addr;
  logic                   instr_ack;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic                   mem_req;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_addr;
  logic                   mem_ack;

  modport master (
    output instr_req, instr_addr, mem_req, mem_we, mem_addr,
    input  instr_ack, instr_data, mem_ack
  );

  modport slave (
    input  instr_req, instr_addr, mem_req, mem_we, mem_addr,
    output instr_ack, instr_data, mem_ack
  );
endinterface

// File: rtl/operand_seq_ctrl_instr_decode.sv
// Combinational field extraction for the latched instruction word.
// Illegal opcodes are reported separately and presented as NOP.
module instr_decode
  import operand_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  output opcode_e                op,
  output logic                   illegal_op,
  output logic [1:0]             rd,
  output logic [1:0]             rs,
  output logic [DATA_WIDTH-1:0]  imm
);

  assign rd  = instr[11:10];
  assign rs  = instr[9:8];
  assign imm = DATA_WIDTH'(instr[7:0]);

  // Map the opcode field onto the legal set, folding everything else to NOP
  always_comb begin
    illegal_op = !opcode_is_legal(instr[15:12]);
    op         = OP_NOP;
    if (!illegal_op) op = opcode_e'(instr[15:12]);
  end

endmodule

// File: rtl/operand_seq_ctrl.sv
// Operand sequencing controller: fetches 16-bit instructions, decodes them
// and steers register-file / memory / immediate operand traffic.
module operand_seq_ctrl
  import operand_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MUX_SELECT_BITS = 2,
  parameter int INSTR_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  operand_seq_ctrl_if.master         bus,
  output logic [MUX_SELECT_BITS-1:0] sel,
  output logic                       rf_we,
  output logic [1:0]                 rf_waddr,
  output logic [1:0]                 rf_raddr,
  output logic [DATA_WIDTH-1:0]      imm_out,
  output logic [DATA_WIDTH-1:0]      pc,
  output logic                       busy,
  output logic                       halted,
  output logic                       illegal
);

  state_e                 state, state_nxt;
  logic [INSTR_WIDTH-1:0] ir;
  opcode_e                dec_op;
  logic                   dec_illegal;
  logic [1:0]             dec_rd, dec_rs;
  logic [DATA_WIDTH-1:0]  dec_imm;
  logic                   fetch_done, jmp_take, illegal_take;
  logic                   instr_req, mem_req, mem_we;
  logic [DATA_WIDTH-1:0]  mem_addr;

  instr_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_decode (
    .instr     (ir),
    .op        (dec_op),
    .illegal_op(dec_illegal),
    .rd        (dec_rd),
    .rs        (dec_rs),
    .imm       (dec_imm)
  );

  assign bus.instr_req  = instr_req;
  assign bus.instr_addr = pc;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign imm_out        = dec_imm;
  assign busy           = (state != ST_IDLE) && (state != ST_HALT);
  assign halted         = (state == ST_HALT);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Program counter, instruction latch and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      if (fetch_done) begin
        ir <= bus.instr_data;
        pc <= pc + DATA_WIDTH'(1);
      end else if (jmp_take) begin
        pc <= dec_imm;
      end
      if (illegal_take) illegal <= 1'b1;
    end
  end

  // Next-state and per-state outputs; acks are only looked at while the
  // matching request is being driven, so stray acks have no effect.
  always_comb begin
    state_nxt    = state;
    instr_req    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    sel          = MUX_SELECT_BITS'(SEL_RF);
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_raddr     = '0;
    fetch_done   = 1'b0;
    jmp_take     = 1'b0;
    illegal_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        instr_req = 1'b1;
        if (bus.instr_ack) begin
          fetch_done = 1'b1;
          state_nxt  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        illegal_take = dec_illegal;
        case (dec_op)
          OP_MOV, OP_LDI: state_nxt = ST_WB;
          OP_LD:          state_nxt = ST_MEM_RD;
          OP_ST:          state_nxt = ST_MEM_WR;
          OP_HALT:        state_nxt = ST_HALT;
          OP_JMP: begin
            jmp_take  = 1'b1;
            state_nxt = ST_FETCH;
          end
          default:        state_nxt = ST_FETCH;
        endcase
      end
      ST_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = dec_rd;
        state_nxt = ST_FETCH;
        if (dec_op == OP_MOV) begin
          sel      = MUX_SELECT_BITS'(SEL_RF);
          rf_raddr = dec_rs;
        end else begin
          sel = MUX_SELECT_BITS'(SEL_IMM);
        end
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = dec_imm;
        sel      = MUX_SELECT_BITS'(SEL_MEM);
        if (bus.mem_ack) begin
          rf_we     = 1'b1;
          rf_waddr  = dec_rd;
          state_nxt = ST_FETCH;
        end
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dec_imm;
        sel      = MUX_SELECT_BITS'(SEL_RF);
        rf_raddr = dec_rs;
        if (bus.mem_ack) state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Directed bench for operand_seq_ctrl: small programs in an instruction ROM,
// a combinational fetch responder and hand-driven data-memory acks.
module tb_operand_seq_ctrl;
  import operand_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] sel;
  logic       rf_we;
  logic [1:0] rf_waddr, rf_raddr;
  logic [7:0] imm_out, pc;
  logic       busy, halted, illegal;
  logic       iack_en;
  logic [15:0] prog [256];

  int n_checks = 0;
  int n_fail   = 0;

  operand_seq_ctrl_if #(.DATA_WIDTH(8), .INSTR_WIDTH(16)) ifc ();

  operand_seq_ctrl #(
    .DATA_WIDTH     (8),
    .MUX_SELECT_BITS(2),
    .INSTR_WIDTH    (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (ifc.master),
    .sel     (sel),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_raddr(rf_raddr),
    .imm_out (imm_out),
    .pc      (pc),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Instruction ROM answers in the same cycle as the request when enabled
  assign ifc.instr_ack  = ifc.instr_req & iack_en;
  assign ifc.instr_data = prog[ifc.instr_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    ifc.mem_ack = 1'b0;
    iack_en     = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    iack_en     = 1'b1;
    ifc.mem_ack = 1'b0;
    clear_prog();
    // LDI r1,0x5A ; MOV r2,r1 ; HALT
    prog[0] = 16'h245A;
    prog[1] = 16'h1900;
    prog[2] = 16'hF000;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_instr_req", ifc.instr_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_sel", sel, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_imm", imm_out, 0);
    do_reset();
    tick();
    chk("idle_no_req", ifc.instr_req, 0);
    chk("idle_busy", busy, 0);

    // ---- LDI / MOV / HALT ----
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f0_req", ifc.instr_req, 1);
    chk("f0_addr", ifc.instr_addr, 8'h00);
    chk("f0_busy", busy, 1);
    tick();
    chk("d0_rf_we", rf_we, 0);
    chk("d0_pc", pc, 1);
    tick();
    chk("ldi_rf_we", rf_we, 1);
    chk("ldi_sel", sel, 2'b10);
    chk("ldi_waddr", rf_waddr, 1);
    chk("ldi_imm", imm_out, 8'h5A);
    tick();
    chk("f1_rf_we", rf_we, 0);
    chk("f1_addr", ifc.instr_addr, 8'h01);
    tick();
    tick();
    chk("mov_rf_we", rf_we, 1);
    chk("mov_sel", sel, 2'b00);
    chk("mov_waddr", rf_waddr, 2);
    chk("mov_raddr", rf_raddr, 1);
    tick();
    tick();
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_ignores_start", halted, 1);
    chk("halt_no_req", ifc.instr_req, 0);

    // ---- LD r3,[0x40] with a 4-cycle ack delay ----
    clear_prog();
    prog[0] = 16'h3C40;
    prog[1] = 16'hF000;
    do_reset();
    chk("post_rst_halted", halted, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ld_wait_req", ifc.mem_req, 1);
      chk("ld_wait_we", ifc.mem_we, 0);
      chk("ld_wait_addr", ifc.mem_addr, 8'h40);
      chk("ld_wait_sel", sel, 2'b01);
      chk("ld_wait_rf_we", rf_we, 0);
      tick();
    end
    ifc.mem_ack = 1'b1;
    #1;
    chk("ld_ack_rf_we", rf_we, 1);
    chk("ld_ack_waddr", rf_waddr, 3);
    chk("ld_ack_sel", sel, 2'b01);
    tick();
    ifc.mem_ack = 1'b0;
    chk("ld_done_req", ifc.mem_req, 0);
    chk("ld_done_rf_we", rf_we, 0);
    chk("ld_done_sel", sel, 0);
    chk("ld_done_fetch", ifc.instr_addr, 8'h01);

    // ---- ST [0x10],r2 ----
    clear_prog();
    prog[0] = 16'h4210;
    prog[1] = 16'hF000;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("st_req", ifc.mem_req, 1);
    chk("st_we", ifc.mem_we, 1);
    chk("st_addr", ifc.mem_addr, 8'h10);
    chk("st_raddr", rf_raddr, 2);
    chk("st_sel", sel, 0);
    chk("st_rf_we", rf_we, 0);
    tick();
    chk("st_hold_we", ifc.mem_we, 1);
    ifc.mem_ack = 1'b1;
    #1;
    chk("st_ack_rf_we", rf_we, 0);
    tick();
    ifc.mem_ack = 1'b0;
    chk("st_done_req", ifc.mem_req, 0);
    chk("st_done_fetch", ifc.instr_addr, 8'h01);
    tick();
    tick();
    chk("st_halted", halted, 1);

    // ---- JMP 0xFF then NOP at 0xFF wraps to 0x00 ----
    clear_prog();
    prog[0]   = 16'h50FF;
    prog[255] = 16'h0000;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("jmp_fetch_addr", ifc.instr_addr, 8'hFF);
    chk("jmp_fetch_req", ifc.instr_req, 1);
    tick();
    chk("wrap_pc", pc, 8'h00);
    tick();
    chk("wrap_fetch_addr", ifc.instr_addr, 8'h00);
    chk("wrap_fetch_req", ifc.instr_req, 1);

    // ---- Illegal opcode 0x7, with a stalled fetch first ----
    clear_prog();
    prog[0] = 16'h7000;
    prog[1] = 16'hF000;
    do_reset();
    iack_en = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stall_req", ifc.instr_req, 1);
    chk("stall_pc", pc, 0);
    iack_en = 1'b1;
    tick();
    chk("ill_decode_pc", pc, 1);
    tick();
    chk("ill_flag", illegal, 1);
    chk("ill_next_addr", ifc.instr_addr, 8'h01);
    chk("ill_rf_we", rf_we, 0);
    tick();
    tick();
    chk("ill_sticky", illegal, 1);
    chk("ill_halted", halted, 1);

    // ---- Reset while waiting for mem_ack ----
    clear_prog();
    prog[0] = 16'h3C40;
    do_reset();
    chk("rst_clears_illegal", illegal, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_mem_req", ifc.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_req", ifc.mem_req, 0);
    chk("async_busy", busy, 0);
    chk("async_sel", sel, 0);
    ifc.mem_ack = 1'b1;
    tick();
    chk("late_ack_rf_we", rf_we, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("late_ack_mem_req", ifc.mem_req, 0);
    chk("late_ack_instr_req", ifc.instr_req, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_rf_we2", rf_we, 0);
    ifc.mem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
